// File: rtl/risc_instrn_sequencer.sv
// ============================================================================
//  Module   : risc_instrn_sequencer
//  Purpose  : Program sequencer in front of RISC_CORE. Buffers host-pushed
//             instructions in a small FIFO, keeps the core in reset until
//             Start, then hands out one instruction per Rd_Instr strobe.
//             Detects end of program, halts on stack overflow and keeps
//             saturating issue/result counters.
//  Ports    : Clk, Reset                     - clock, sync active-high reset
//             Host_Valid/Ready/Instrn/Last    - host push interface
//             Start                           - run / clear pulse
//             Rd_Instr, EndOfInstrn,
//             OUT_VALID, STACK_FULL           - status from core
//             Instrn, Core_Reset,
//             Enbl_RegFile, Enbl_Stack        - controls to core
//             Busy, Done, Halted, Underrun,
//             Instr_Cnt, Result_Cnt           - status to host
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc_instrn_sequencer #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Host_Valid,
  output logic               Host_Ready,
  input  logic [INSTR_W-1:0] Host_Instrn,
  input  logic               Host_Last,
  input  logic               Start,
  input  logic               Rd_Instr,
  input  logic               EndOfInstrn,
  input  logic               OUT_VALID,
  input  logic               STACK_FULL,
  output logic [INSTR_W-1:0] Instrn,
  output logic               Core_Reset,
  output logic               Enbl_RegFile,
  output logic               Enbl_Stack,
  output logic               Busy,
  output logic               Done,
  output logic               Halted,
  output logic               Underrun,
  output logic [CNT_W-1:0]   Instr_Cnt,
  output logic [CNT_W-1:0]   Result_Cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] C_DEPTH   = FCNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;
  localparam logic [PTR_W-1:0]  C_PTR_ONE = PTR_W'(1);
  localparam logic [FCNT_W-1:0] C_CNT_ONE = FCNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state_q;
  logic [INSTR_W:0]    mem_q [DEPTH];   // MSB is the last-instruction flag
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]   count_q;
  logic [CNT_W-1:0]    instr_cnt_q, result_cnt_q;
  logic                underrun_q;

  logic                w_not_empty, w_active, w_push, w_pop, w_underrun;
  logic [INSTR_W:0]    w_head;

  assign w_not_empty = (count_q != '0);
  assign w_active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign w_head      = mem_q[rd_ptr_q];

  // Ready is taken from the registered count: a pop in the same cycle
  // never makes room for a push into a full FIFO.
  assign Host_Ready = (count_q < C_DEPTH) && (state_q != S_HALT);
  assign w_push     = Host_Valid && Host_Ready;

  // STACK_FULL wins over any pop in the same cycle.
  assign w_pop      = (state_q == S_RUN) && Rd_Instr && w_not_empty && !STACK_FULL;
  assign w_underrun = (state_q == S_RUN) && Rd_Instr && !w_not_empty && !STACK_FULL;

  // Head is muxed straight from storage so the core sees a new word
  // as soon as the read pointer moves.
  assign Instrn = ((state_q == S_RUN) && w_not_empty) ? w_head[INSTR_W-1:0] : '0;

  // Core stays alive in HALT so its state can be inspected.
  assign Core_Reset   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign Enbl_RegFile = w_active;
  assign Enbl_Stack   = w_active;
  assign Busy         = w_active;
  assign Done         = (state_q == S_DONE);
  assign Halted       = (state_q == S_HALT);
  assign Underrun     = underrun_q;
  assign Instr_Cnt    = instr_cnt_q;
  assign Result_Cnt   = result_cnt_q;

  // Storage has no reset; validity is tracked by count_q alone.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {Host_Last, Host_Instrn};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      instr_cnt_q  <= '0;
      result_cnt_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;

      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + C_CNT_ONE;
        2'b01:   count_q <= count_q - C_CNT_ONE;
        default: count_q <= count_q;
      endcase

      if (w_pop && (instr_cnt_q != C_CNT_MAX)) instr_cnt_q <= instr_cnt_q + 1'b1;
      if (w_active && OUT_VALID && (result_cnt_q != C_CNT_MAX))
        result_cnt_q <= result_cnt_q + 1'b1;
      if (w_underrun) underrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (Start && w_not_empty) begin
            state_q      <= S_RUN;
            instr_cnt_q  <= '0;
            result_cnt_q <= '0;
            underrun_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (STACK_FULL)                  state_q <= S_HALT;
          else if (w_pop && w_head[INSTR_W]) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (STACK_FULL)       state_q <= S_HALT;
          else if (EndOfInstrn) state_q <= S_DONE;
        end
        S_DONE: begin
          if (Start) state_q <= S_IDLE;
        end
        S_HALT: begin
          // Leaving HALT discards whatever program was still queued.
          if (Start) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc_instrn_sequencer.sv
// ============================================================================
//  Module   : tb_risc_instrn_sequencer
//  Purpose  : Self-checking bench for risc_instrn_sequencer. Words pushed by
//             the host are queued as expected issues and popped/compared
//             when the core strobes Rd_Instr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_risc_instrn_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Host_Valid, Host_Last, Start, Rd_Instr;
  logic        EndOfInstrn, OUT_VALID, STACK_FULL;
  logic [31:0] Host_Instrn;
  logic        Host_Ready, Core_Reset, Enbl_RegFile, Enbl_Stack;
  logic        Busy, Done, Halted, Underrun;
  logic [31:0] Instrn;
  logic [7:0]  Instr_Cnt, Result_Cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;

  risc_instrn_sequencer #(.DEPTH(8), .INSTR_W(32), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Host_Valid(Host_Valid), .Host_Ready(Host_Ready),
    .Host_Instrn(Host_Instrn), .Host_Last(Host_Last),
    .Start(Start), .Rd_Instr(Rd_Instr), .EndOfInstrn(EndOfInstrn),
    .OUT_VALID(OUT_VALID), .STACK_FULL(STACK_FULL),
    .Instrn(Instrn), .Core_Reset(Core_Reset),
    .Enbl_RegFile(Enbl_RegFile), .Enbl_Stack(Enbl_Stack),
    .Busy(Busy), .Done(Done), .Halted(Halted), .Underrun(Underrun),
    .Instr_Cnt(Instr_Cnt), .Result_Cnt(Result_Cnt)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Host_Valid = 0; Host_Last = 0; Host_Instrn = '0; Start = 0;
    Rd_Instr = 0; EndOfInstrn = 0; OUT_VALID = 0; STACK_FULL = 0;
    tick();
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [31:0] w, input logic last);
    Host_Valid = 1'b1; Host_Instrn = w; Host_Last = last;
    if (Host_Ready) exp_q.push_back(w);
    tick();
    Host_Valid = 1'b0; Host_Last = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  // One Rd_Instr strobe; returns what the core saw and what the model expects.
  task automatic issue(output logic [31:0] got, output logic [31:0] exp);
    Rd_Instr = 1'b1;
    #1;
    got = Instrn;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
    tick();
    Rd_Instr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Core_Reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b expected 1", Core_Reset); end
    checks++; if ({Enbl_RegFile, Enbl_Stack, Busy, Done, Halted, Underrun} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {Enbl_RegFile, Enbl_Stack, Busy, Done, Halted, Underrun}); end
    checks++; if ({Instrn, Instr_Cnt, Result_Cnt} !== 48'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {Instrn, Instr_Cnt, Result_Cnt}); end
    checks++; if (Host_Ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b expected 1", Host_Ready); end
  endtask

  task automatic test_basic_program();
    logic [31:0] got, exp;
    do_reset();
    push_word(32'h0100_0001, 1'b0);
    push_word(32'h0200_0002, 1'b0);
    push_word(32'h0300_0003, 1'b1);
    pulse_start();
    checks++; if ({Busy, Core_Reset, Enbl_RegFile, Enbl_Stack} !== 4'b1011) begin errors++; $display("FAIL basic_run_state: got %b expected 1011", {Busy, Core_Reset, Enbl_RegFile, Enbl_Stack}); end
    for (int i = 0; i < 3; i++) begin
      issue(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL basic_issue%0d: got %h expected %h", i, got, exp); end
    end
    checks++; if (Instr_Cnt !== 8'd3) begin errors++; $display("FAIL basic_instr_cnt: got %0d expected 3", Instr_Cnt); end
    checks++; if ({Busy, Done, Instrn} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL basic_drain: got busy=%b done=%b instrn=%h expected 1 0 0", Busy, Done, Instrn); end
    EndOfInstrn = 1'b1; tick(); EndOfInstrn = 1'b0;
    checks++; if ({Done, Core_Reset, Busy, Enbl_RegFile} !== 4'b1100) begin errors++; $display("FAIL basic_done: got %b expected 1100", {Done, Core_Reset, Busy, Enbl_RegFile}); end
    checks++; if (Host_Ready !== 1'b1) begin errors++; $display("FAIL basic_done_ready: got %b expected 1", Host_Ready); end
    pulse_start();
    checks++; if ({Done, Core_Reset, Busy} !== 3'b010) begin errors++; $display("FAIL basic_back_to_idle: got %b expected 010", {Done, Core_Reset, Busy}); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] got, exp;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + i, 1'b0);
    checks++; if (Host_Ready !== 1'b0) begin errors++; $display("FAIL full_ready_after8: got %b expected 0", Host_Ready); end
    push_word(32'hDEAD_BEEF, 1'b0);   // must be refused
    pulse_start();
    issue(got, exp);
    checks++; if (got !== exp) begin errors++; $display("FAIL full_pop1: got %h expected %h", got, exp); end
    checks++; if (Host_Ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", Host_Ready); end
    push_word(32'hA5A5_000A, 1'b0);
    checks++; if (Host_Ready !== 1'b0) begin errors++; $display("FAIL full_ready_refill: got %b expected 0", Host_Ready); end
    // Push+pop while full: the pop happens, the push is refused.
    Host_Valid = 1'b1; Host_Instrn = 32'hA5A5_000B;
    if (Host_Ready) exp_q.push_back(Host_Instrn);
    issue(got, exp);
    Host_Valid = 1'b0;
    checks++; if (got !== exp) begin errors++; $display("FAIL full_pushpop_full: got %h expected %h", got, exp); end
    checks++; if (Host_Ready !== 1'b1) begin errors++; $display("FAIL full_ready_7: got %b expected 1", Host_Ready); end
    // Push+pop with room: count stays at 7.
    Host_Valid = 1'b1; Host_Instrn = 32'hA5A5_000C;
    if (Host_Ready) exp_q.push_back(Host_Instrn);
    issue(got, exp);
    Host_Valid = 1'b0;
    checks++; if (got !== exp) begin errors++; $display("FAIL full_pushpop: got %h expected %h", got, exp); end
    checks++; if (Host_Ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_count: got %b expected 1", Host_Ready); end
    push_word(32'hA5A5_000D, 1'b0);
    checks++; if (Host_Ready !== 1'b0) begin errors++; $display("FAIL full_ready_8_again: got %b expected 0", Host_Ready); end
    for (int i = 0; i < 8; i++) begin
      issue(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, got, exp); end
    end
    checks++; if ({Instr_Cnt, Underrun} !== {8'd11, 1'b0}) begin errors++; $display("FAIL full_cnt: got %0d/%b expected 11/0", Instr_Cnt, Underrun); end
  endtask

  task automatic test_underrun();
    logic [31:0] got, exp;
    do_reset();
    push_word(32'h0000_00A1, 1'b0);
    push_word(32'h0000_00A2, 1'b0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      issue(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL underrun_issue%0d: got %h expected %h", i, got, exp); end
    end
    checks++; if ({Underrun, Instr_Cnt, Busy, Done} !== {1'b1, 8'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL underrun_state: got u=%b cnt=%0d busy=%b done=%b expected 1 2 1 0", Underrun, Instr_Cnt, Busy, Done); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h4000_0000 + i, 1'b0);
    pulse_start();
    Rd_Instr = 1'b1; STACK_FULL = 1'b1; tick(); Rd_Instr = 1'b0; STACK_FULL = 1'b0;
    checks++; if ({Halted, Busy, Enbl_RegFile, Enbl_Stack, Core_Reset, Host_Ready} !== 6'b100000) begin errors++; $display("FAIL halt_flags: got %b expected 100000", {Halted, Busy, Enbl_RegFile, Enbl_Stack, Core_Reset, Host_Ready}); end
    checks++; if ({Instr_Cnt, Instrn} !== 40'h0) begin errors++; $display("FAIL halt_no_pop: got cnt=%0d instrn=%h expected 0 0", Instr_Cnt, Instrn); end
    pulse_start();
    checks++; if ({Halted, Core_Reset, Host_Ready} !== 3'b011) begin errors++; $display("FAIL halt_to_idle: got %b expected 011", {Halted, Core_Reset, Host_Ready}); end
    exp_q.delete();
    // Flushed FIFO: a further Start must be ignored.
    pulse_start();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL halt_flushed: got busy=%b expected 0", Busy); end
  endtask

  task automatic test_result_saturate();
    do_reset();
    OUT_VALID = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    OUT_VALID = 1'b0;
    checks++; if (Result_Cnt !== 8'd0) begin errors++; $display("FAIL result_idle: got %0d expected 0", Result_Cnt); end
    push_word(32'h0000_0055, 1'b0);
    pulse_start();
    OUT_VALID = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 9) begin
        checks++; if (Result_Cnt !== 8'd10) begin errors++; $display("FAIL result_partial: got %0d expected 10", Result_Cnt); end
      end
    end
    OUT_VALID = 1'b0;
    checks++; if (Result_Cnt !== 8'd255) begin errors++; $display("FAIL result_saturate: got %0d expected 255", Result_Cnt); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] got, exp;
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'h6000_0000 + i, 1'b0);
    pulse_start();
    issue(got, exp);
    OUT_VALID = 1'b1; tick(); OUT_VALID = 1'b0;
    checks++; if ({Instr_Cnt, Result_Cnt} !== {8'd1, 8'd1}) begin errors++; $display("FAIL midrun_pre: got %0d/%0d expected 1/1", Instr_Cnt, Result_Cnt); end
    Reset = 1'b1; tick(); Reset = 1'b0;
    exp_q.delete();
    checks++; if ({Busy, Core_Reset, Host_Ready, Underrun} !== 4'b0110) begin errors++; $display("FAIL midrun_flags: got %b expected 0110", {Busy, Core_Reset, Host_Ready, Underrun}); end
    checks++; if ({Instrn, Instr_Cnt, Result_Cnt} !== 48'h0) begin errors++; $display("FAIL midrun_data: got %h expected 0", {Instrn, Instr_Cnt, Result_Cnt}); end
    pulse_start();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrun_empty: got busy=%b expected 0", Busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_program();
    test_fifo_full();
    test_underrun();
    test_halt();
    test_result_saturate();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
